// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter over an edge-triggered valid/ready handshake
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int GAP = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          tx_data_valid,
    output logic [7:0]    tx_data,
    input  logic          tx_ready,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    localparam int GW = $clog2(GAP + 1);
    localparam logic [GW-1:0] GAP_LD = GW'(GAP);
    localparam logic [AW:0] LV1 = 1;
    localparam logic [AW:0] FULL_LV = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] P1 = 1;
    state_t state_q, state_d;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] level_d;
    logic [GW-1:0] gap_cnt;
    logic push, pop;
    assign push = wr_en && !full && !flush;
    assign pop = state_q == IDLE && !empty && tx_ready && gap_cnt == '0 && !flush;
    assign busy = state_q != IDLE || !empty;
    // next state: issue when a byte is waiting, wait for the latch ack, then wait for the frame to finish
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pop ? ISSUE : IDLE;
            ISSUE:   state_d = tx_ready ? ISSUE : DRAIN;
            DRAIN:   state_d = tx_ready ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    // occupancy after this edge, ignoring flush
    always_comb begin
        level_d = level;
        if (push && !pop) level_d = level + LV1;
        else if (!push && pop) level_d = level - LV1;
    end
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    // pointers, flags, registered handshake outputs and the inter-byte gap counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            empty <= 1'b1;
            full <= 1'b0;
            overflow <= 1'b0;
            tx_data_valid <= 1'b0;
            tx_data <= 8'h00;
            gap_cnt <= GAP_LD;
        end else begin
            tx_data_valid <= state_d == ISSUE;
            overflow <= wr_en && full && !flush;
            if (pop) tx_data <= mem[rd_ptr];
            gap_cnt <= state_d == DRAIN ? GAP_LD :
                       (state_q == IDLE && gap_cnt != '0) ? gap_cnt - GW'(1) : gap_cnt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level <= '0;
                empty <= 1'b1;
                full <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + P1;
                if (pop) rd_ptr <= rd_ptr + P1;
                level <= level_d;
                empty <= level_d == '0;
                full <= level_d == FULL_LV;
            end
        end
    end
    // storage needs no reset; only entries behind the pointers are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench pairing the FIFO with a behavioural 8-clocks-per-bit transmitter and line receiver
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic flush = 1'b0;
    logic full, empty, overflow, tx_data_valid, busy;
    logic [4:0] level;
    logic [7:0] tx_data;
    logic tx_ready;
    logic tx_hold = 1'b0;
    int checks = 0;
    int errors = 0;

    logic v1, v2, rdy, line, tx_on;
    logic [9:0] sh;
    int cnt;
    logic rx_on;
    logic [9:0] rf;
    int rc;
    logic [9:0] rx_q[$];
    logic vprev = 1'b0;
    logic [7:0] held;

    uart_tx_fifo dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .tx_data_valid(tx_data_valid), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    assign tx_ready = rdy && !tx_hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // transmitter: 2-flop edge detect on valid, latch, drop ready, shift 10 bits at 8 clocks each
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0; v2 <= 1'b0; rdy <= 1'b1; line <= 1'b1; tx_on <= 1'b0; cnt <= 0; sh <= '0;
        end else begin
            v1 <= tx_data_valid;
            v2 <= v1;
            if (!tx_on) begin
                if (v1 && !v2) begin
                    sh <= {1'b1, tx_data, 1'b0};
                    tx_on <= 1'b1; rdy <= 1'b0; cnt <= 0; line <= 1'b0;
                end
            end else begin
                cnt <= cnt + 1;
                if (cnt == 79) begin
                    tx_on <= 1'b0; rdy <= 1'b1; line <= 1'b1;
                end else if (cnt % 8 == 7) line <= sh[(cnt + 1) / 8];
            end
        end
    end

    // line receiver: sample mid-bit, store whole frame with start bit in [0]
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_on <= 1'b0; rc <= 0; rf <= '0;
        end else if (!rx_on) begin
            if (line == 1'b0) begin
                rx_on <= 1'b1; rc <= 0;
            end
        end else begin
            rc <= rc + 1;
            if (rc == 75) begin
                rx_q.push_back({line, rf[8:0]});
                rx_on <= 1'b0;
            end else if (rc % 8 == 3) rf[rc / 8] <= line;
        end
    end

    // tx_data must not move while valid stays high
    always @(negedge clk) begin
        if (tx_data_valid && vprev) chk("hold", tx_data, held);
        held = tx_data;
        vprev = tx_data_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || !tx_ready || rx_on) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("idle_timeout", 1, 0);
        repeat (4) tick();
    endtask

    task automatic chk_rx(input logic [7:0] b);
        if (rx_q.size() == 0) chk("rx_missing", 0, {22'd0, 1'b1, b, 1'b0});
        else chk("rx_frame", rx_q.pop_front(), {22'd0, 1'b1, b, 1'b0});
    endtask

    initial begin
        int n;
        int ov_cnt;
        // 1: reset, then transmitter not ready holds the FIFO in IDLE
        tx_hold = 1'b1;
        repeat (5) tick();
        chk("rst_valid", tx_data_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", tx_data, 0);
        rst = 1'b1;
        repeat (3) tick();
        push(8'h11);
        chk("t1_empty", empty, 0);
        chk("t1_level", level, 1);
        repeat (6) tick();
        chk("t1_no_valid", tx_data_valid, 0);
        chk("t1_level_held", level, 1);
        tx_hold = 1'b0;
        tick();
        chk("t1_valid", tx_data_valid, 1);
        chk("t1_data", tx_data, 8'h11);
        wait_idle(500);
        chk_rx(8'h11);
        // 2: single byte latency and frame
        push(8'hA5);
        chk("t2_empty", empty, 0);
        chk("t2_valid_early", tx_data_valid, 0);
        tick();
        chk("t2_valid", tx_data_valid, 1);
        chk("t2_data", tx_data, 8'hA5);
        chk("t2_level", level, 0);
        chk("t2_busy", busy, 1);
        n = 0;
        while (tx_data_valid && n < 20) begin tick(); n++; end
        chk("t2_valid_fell", tx_data_valid, 0);
        chk("t2_ack_seen", tx_ready, 0);
        wait_idle(500);
        chk_rx(8'hA5);
        chk("t2_rx_count", rx_q.size(), 0);
        // 3: fill to full with transmitter stalled, 17th write overflows
        tx_hold = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
            ov_cnt += int'(overflow);
        end
        chk("t3_ovf_early", ov_cnt, 0);
        chk("t3_full_16", full, 1);
        wr_data = 8'hFF;
        tick();
        chk("t3_ovf17", overflow, 1);
        chk("t3_level", level, 16);
        chk("t3_full", full, 1);
        // 4: write while full in the same cycle as the pop
        wr_data = 8'hEE;
        tx_hold = 1'b0;
        tick();
        wr_en = 1'b0;
        chk("t4_ovf", overflow, 1);
        chk("t4_level", level, 15);
        chk("t4_full", full, 0);
        chk("t4_valid", tx_data_valid, 1);
        chk("t4_data", tx_data, 8'h00);
        tick();
        chk("t4_ovf_pulse", overflow, 0);
        wait_idle(3000);
        for (int i = 0; i < 16; i++) chk_rx(8'(i));
        chk("t3_rx_count", rx_q.size(), 0);
        // 5: flush while byte 0 drains
        for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
        n = 0;
        while ((tx_data_valid || tx_ready) && n < 50) begin tick(); n++; end
        chk("t5_in_drain", n < 50, 1);
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h99;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        chk("t5_level", level, 0);
        chk("t5_empty", empty, 1);
        chk("t5_full", full, 0);
        chk("t5_ovf", overflow, 0);
        chk("t5_busy", busy, 1);
        tick();
        chk("t5_ovf_after", overflow, 0);
        wait_idle(1000);
        chk_rx(8'h50);
        chk("t5_rx_count", rx_q.size(), 0);
        // 6: async reset while in ISSUE, then recover
        push(8'h77);
        push(8'h78);
        n = 0;
        while (!tx_data_valid && n < 10) begin tick(); n++; end
        chk("t6_valid", tx_data_valid, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", tx_data_valid, 0);
        chk("t6_rst_data", tx_data, 0);
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_full", full, 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        push(8'h3C);
        tick();
        chk("t6_new_valid", tx_data_valid, 1);
        chk("t6_new_data", tx_data, 8'h3C);
        wait_idle(500);
        chk_rx(8'h3C);
        chk("t6_rx_count", rx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
